// File: rtl/pwm_pkg.sv
// pwm_pkg: register map and CTRL bit positions shared by the multi-channel PWM block
package pwm_pkg;
    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_PERIOD   = 1;
    localparam int ADDR_PRESCALE = 2;
    localparam int ADDR_CHEN     = 3;
    localparam int ADDR_DUTY0    = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_POL      = 1;
    localparam int CTRL_PEND     = 2;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with a shadowed duty register and a registered polarity-adjusted compare
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wrap,
    input  logic             load,
    input  logic             en,
    input  logic             ch_en,
    input  logic             pol,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] duty_sh,
    output logic             pend,
    output logic             out
);
    logic [CNT_W-1:0] duty_act;
    assign pend = duty_sh != duty_act;
    // a wrap takes the old shadow, while an enable edge takes a value written in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_sh  <= '0;
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (we) duty_sh <= wdata;
            if (load) duty_act <= we ? wdata : duty_sh;
            else if (wrap) duty_act <= duty_sh;
            out <= (en & ch_en & (cnt < duty_act)) ^ pol;
        end
    end
endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator behind an Avalon-MM style slave port,
// with a shared prescaler/counter/period and per-channel shadowed duty registers.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 7,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port
);
    logic              wr, tick, wrap, en_rise, pend, ctrl_en, ctrl_pol, unused_wdata;
    int                addr_i;
    logic [CNT_W-1:0]  period_sh, per_act, cnt;
    logic [PRE_W-1:0]  prescale, pre_cnt;
    logic [NUM_CH-1:0] ch_en, duty_pend;
    logic [CNT_W-1:0]  duty_sh [NUM_CH];
    assign addr_i       = int'(address);
    assign wr           = chipselect & ~write_n;
    assign en_rise      = wr & (addr_i == ADDR_CTRL) & writedata[CTRL_EN] & ~ctrl_en;
    assign tick         = pre_cnt == prescale;
    assign wrap         = ctrl_en & tick & (cnt == per_act);
    assign pend         = (period_sh != per_act) | (|duty_pend);
    assign unused_wdata = ^writedata;
    // counters sit at 0 while disabled, so an enable edge always starts a fresh period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_pol  <= 1'b0;
            period_sh <= '0;
            per_act   <= '0;
            prescale  <= '0;
            ch_en     <= '0;
            pre_cnt   <= '0;
            cnt       <= '0;
        end else begin
            if (wr && addr_i == ADDR_CTRL) begin
                ctrl_en  <= writedata[CTRL_EN];
                ctrl_pol <= writedata[CTRL_POL];
            end
            if (wr && addr_i == ADDR_PERIOD) period_sh <= writedata[CNT_W-1:0];
            if (wr && addr_i == ADDR_PRESCALE) prescale <= writedata[PRE_W-1:0];
            if (wr && addr_i == ADDR_CHEN) ch_en <= writedata[NUM_CH-1:0];
            if (en_rise || wrap) per_act <= period_sh;
            pre_cnt <= (!ctrl_en || tick) ? '0 : pre_cnt + 1'b1;
            cnt     <= !ctrl_en ? '0 : !tick ? cnt : (cnt == per_act) ? '0 : cnt + 1'b1;
        end
    end
    always_comb begin
        readdata = '0;
        if (addr_i == ADDR_CTRL) begin
            readdata[CTRL_EN]   = ctrl_en;
            readdata[CTRL_POL]  = ctrl_pol;
            readdata[CTRL_PEND] = pend;
        end
        else if (addr_i == ADDR_PERIOD) readdata[CNT_W-1:0] = period_sh;
        else if (addr_i == ADDR_PRESCALE) readdata[PRE_W-1:0] = prescale;
        else if (addr_i == ADDR_CHEN) readdata[NUM_CH-1:0] = ch_en;
        for (int k = 0; k < NUM_CH; k++)
            if (addr_i == ADDR_DUTY0 + k) readdata[CNT_W-1:0] = duty_sh[k];
    end
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .cnt    (cnt),
            .wrap   (wrap),
            .load   (en_rise),
            .en     (ctrl_en),
            .ch_en  (ch_en[k]),
            .pol    (ctrl_pol),
            .we     (wr && addr_i == ADDR_DUTY0 + k),
            .wdata  (writedata[CNT_W-1:0]),
            .duty_sh(duty_sh[k]),
            .pend   (duty_pend[k]),
            .out    (out_port[k])
        );
    end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed stimulus pushes expected readdata/out_port values into a queue;
// a negedge monitor pops and compares them against the DUT.
module tb_pwm_multi_ch;
    import pwm_pkg::*;
    logic        clk = 0, reset = 1, chipselect = 0, write_n = 1;
    logic [3:0]  address = 0;
    logic [31:0] writedata = 0, readdata, act;
    logic [6:0]  out_port, pat = 0;
    typedef struct { int due; bit rd; logic [31:0] exp; string name; } exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0, n_chk = 0, n_pass = 0, j = 0, mode = 0, pre = 0, per = 9;
    int chg[3], dv[3];

    pwm_multi_ch dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            act = e.rd ? readdata : {25'b0, out_port};
            n_chk++;
            if (e.due == cyc && act === e.exp) n_pass++;
            else $display("FAIL %s: got %h, expected %h (due %0d, now %0d)", e.name, act, e.exp, e.due, cyc);
        end
    end

    // expected out_port j cycles after an enable write: state i = j-1 drives the output flop
    function automatic logic [31:0] model(int jj);
        int i, c, d;
        if (jj == 0) return 32'd0;
        if (mode == 2) return {25'b0, pat};
        i = jj - 1;
        c = (i / (pre + 1)) % (per + 1);
        d = dv[0];
        for (int k = 1; k < 3; k++) if (i >= chg[k]) d = dv[k];
        return (c < d) ? 32'd1 : 32'd0;
    endfunction

    task automatic push(input bit rd, input logic [31:0] exp, input string name);
        q.push_back('{cyc, rd, exp, name});
    endtask

    task automatic step();
        if (mode != 0) push(1'b0, model(j), $sformatf("out_port j=%0d", j));
        @(posedge clk);
        #1;
        j++;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        address = 4'(a); writedata = d; chipselect = 1; write_n = 0;
        step();
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name);
        address = 4'(a);
        push(1'b1, exp, $sformatf("%s @%0d", name, a));
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        for (int a = 0; a < 16; a++) rd(a, 0, "reset read");
        push(1'b0, 0, "reset out_port");
        step();
        // basic waveform, with out-of-field writedata bits that must be dropped
        wr(ADDR_PRESCALE, 32'h0000_0100);
        wr(ADDR_PERIOD, 32'hABCD_0009);
        wr(ADDR_DUTY0, 3);
        wr(ADDR_CHEN, 1);
        rd(ADDR_PERIOD, 9, "period readback");
        rd(ADDR_PRESCALE, 0, "prescale truncated");
        rd(ADDR_CTRL, 4, "pend before enable");
        chg = '{0, 1000, 1000}; dv = '{3, 3, 3}; pre = 0; per = 9;
        wr(ADDR_CTRL, 1);
        j = 0; mode = 1;
        while (j < 25) step();
        rd(ADDR_CTRL, 1, "ctrl running");
        // prescaler
        mode = 0;
        wr(ADDR_CTRL, 0);
        wr(ADDR_PRESCALE, 32'h0000_0103);
        rd(ADDR_PRESCALE, 3, "prescale readback");
        wr(ADDR_CTRL, 1);
        pre = 3; j = 0; mode = 1;
        while (j < 85) step();
        // shadow timing: mid-period write, then a write landing on the wrap edge
        mode = 0;
        wr(ADDR_CTRL, 0);
        wr(ADDR_PRESCALE, 0);
        wr(ADDR_CTRL, 1);
        pre = 0; chg = '{0, 10, 40}; dv = '{3, 7, 2}; j = 0; mode = 1;
        while (j < 5) step();
        wr(ADDR_DUTY0, 7);
        rd(ADDR_DUTY0, 7, "duty0 shadow readback");
        rd(ADDR_CTRL, 5, "pend after write");
        step();
        rd(ADDR_CTRL, 5, "pend before wrap");
        rd(ADDR_CTRL, 1, "pend cleared at wrap");
        while (j < 29) step();
        wr(ADDR_DUTY0, 2);
        rd(ADDR_CTRL, 5, "pend after wrap-cycle write");
        while (j < 39) step();
        rd(ADDR_CTRL, 5, "pend held one period");
        rd(ADDR_CTRL, 1, "pend cleared next wrap");
        while (j < 55) step();
        // extremes and polarity
        mode = 0;
        wr(ADDR_CTRL, 0);
        wr(ADDR_DUTY0 + 1, 0);
        wr(ADDR_DUTY0 + 2, 15);
        wr(ADDR_CHEN, 6);
        wr(ADDR_CTRL, 3);
        pat = 7'b1111011; j = 0; mode = 2;
        while (j < 20) step();
        rd(ADDR_CTRL, 3, "ctrl en+pol");
        // asynchronous reset mid-period while outputs sit at the inverted level
        mode = 0;
        reset = 1;
        push(1'b0, 0, "async reset out_port");
        @(negedge clk);
        #1 reset = 0;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) rd(a, 0, "post-reset read");
        push(1'b0, 0, "post-reset out_port");
        step();
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL scoreboard drain: %0d checks left, required 0", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
